// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmit stage.
// Accepts a WIDTH-bit word over valid/ready and emits it one bit per clock on sout,
// with a per-bit valid, a last-bit marker and an optional idle gap after each word.
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy,
    output logic [7:0]       word_count
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);
    localparam bit             NoGap   = (GAP == 0);
    // Gap counter counts down to zero, so it is loaded with one less than the gap length.
    localparam logic [3:0]     GapLoad = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic [7:0]       wc_q, wc_d;
    logic             accept;

    function automatic logic out_bit(input logic [WIDTH-1:0] s);
        return LSB_FIRST ? s[0] : s[WIDTH-1];
    endfunction

    // Ready in IDLE, or on the final bit of a word when no gap follows (back-to-back).
    always_comb begin
        din_ready = ~rst & ((state_q == StIdle) |
                            ((state_q == StShift) & (cnt_q == '0) & NoGap));
        accept    = din_valid & din_ready;
    end

    // Next-state logic; registered outputs are derived from the next state.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        wc_d    = wc_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                    shift_d = din;
                    cnt_d   = CntMax;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    wc_d = wc_q + 8'd1;
                    if (!NoGap) begin
                        state_d = StGap;
                        gap_d   = GapLoad;
                        shift_d = '0;
                    end else if (accept) begin
                        shift_d = din;
                        cnt_d   = CntMax;
                    end else begin
                        state_d = StIdle;
                        shift_d = '0;
                    end
                end
            end
            StGap: begin
                if (gap_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                shift_d = '0;
                cnt_d   = '0;
                gap_d   = '0;
            end
        endcase

        valid_d = (state_d == StShift);
        sout_d  = valid_d & out_bit(shift_d);
        last_d  = valid_d & (cnt_d == '0);
        busy_d  = (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            wc_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            wc_q    <= wc_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (LSB-first/no gap and MSB-first/gap 2) share
// stimulus; a timing model predicts ready/valid/busy/count and a queue scoreboard checks bits.
module tb_piso_serializer;

    localparam int W = 4;
    localparam int GAP0 = 0;
    localparam int GAP1 = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;

    logic rdy0, so0, sv0, last0, busy0;
    logic rdy1, so1, sv1, last1, busy1;
    logic [7:0] wc0, wc1;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .GAP(GAP0)) u0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy0),
        .sout(so0), .sout_valid(sv0), .last(last0), .busy(busy0), .word_count(wc0)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .GAP(GAP1)) u1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy1),
        .sout(so1), .sout_valid(sv1), .last(last1), .busy(busy1), .word_count(wc1)
    );

    typedef struct packed {logic b; logic l;} exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    // Reference timing per instance, in units of posedge index e.
    int         e = 0;
    int         vstart[2] = '{-100, -100};
    int         vend[2]   = '{-100, -100};
    int         enext[2]  = '{0, 0};
    bit         pend[2]   = '{1'b0, 1'b0};
    logic [7:0] wc_m[2]   = '{8'd0, 8'd0};
    logic       acc0, acc1;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b want %b", name, e, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d want %0d", name, e, act, exp);
        end
    endtask

    function automatic int gap_of(input int i);
        return (i == 0) ? GAP0 : GAP1;
    endfunction

    task automatic upd(input int i, input logic r, input logic a, input logic [W-1:0] d);
        exp_t x;
        if (r) begin
            pend[i] = 1'b0;
            wc_m[i] = 8'd0;
            vstart[i] = -100;
            vend[i] = -100;
            enext[i] = e + 1;
            if (i == 0) q0.delete(); else q1.delete();
        end else begin
            if (pend[i] && e == vend[i] + 1) begin
                wc_m[i] = wc_m[i] + 8'd1;
                pend[i] = 1'b0;
            end
            if (a) begin
                vstart[i] = e;
                vend[i] = e + W - 1;
                enext[i] = e + W + ((gap_of(i) > 0) ? gap_of(i) + 1 : 0);
                pend[i] = 1'b1;
                for (int k = 0; k < W; k++) begin
                    x.b = (i == 0) ? d[k] : d[W-1-k];
                    x.l = (k == W - 1);
                    if (i == 0) q0.push_back(x); else q1.push_back(x);
                end
            end
        end
    endtask

    task automatic post(input int i, input logic v, input logic s, input logic l,
                        input logic b, input logic [7:0] wc);
        logic ev;
        ev = (e >= vstart[i]) && (e <= vend[i]);
        chk1(i == 0 ? "u0_sout_valid" : "u1_sout_valid", v, ev);
        chk1(i == 0 ? "u0_busy" : "u1_busy", b,
             (e >= vstart[i]) && (e <= vend[i] + gap_of(i)));
        chk8(i == 0 ? "u0_word_count" : "u1_word_count", wc, wc_m[i]);
        if (!ev) begin
            chk1(i == 0 ? "u0_idle_sout" : "u1_idle_sout", s, 1'b0);
            chk1(i == 0 ? "u0_idle_last" : "u1_idle_last", l, 1'b0);
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        logic er0, er1;
        @(negedge clk);
        rst = r;
        din_valid = v;
        din = d;
        #1;
        er0 = !r && (e >= enext[0]);
        er1 = !r && (e >= enext[1]);
        chk1("u0_din_ready", rdy0, er0);
        chk1("u1_din_ready", rdy1, er1);
        acc0 = v && er0;
        acc1 = v && er1;
        @(posedge clk);
        #1;
        upd(0, r, acc0, d);
        upd(1, r, acc1, d);
        post(0, sv0, so0, last0, busy0, wc0);
        post(1, sv1, so1, last1, busy1, wc1);
        e++;
    endtask

    // Scoreboard monitor: pops one expected bit per presented valid bit.
    always @(negedge clk) begin
        exp_t p;
        if (sv0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk1("u0_extra_bit", sv0, 1'b0);
            end else begin
                p = q0.pop_front();
                chk1("u0_sout", so0, p.b);
                chk1("u0_last", last0, p.l);
            end
        end
        if (sv1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk1("u1_extra_bit", sv1, 1'b0);
            end else begin
                p = q1.pop_front();
                chk1("u1_sout", so1, p.b);
                chk1("u1_last", last1, p.l);
            end
        end
    end

    // Holds din_valid and offers words in order until the chosen instance took them all.
    task automatic send_pair(input int inst, input logic [W-1:0] w0, input logic [W-1:0] w1);
        int idx = 0;
        int budget = 0;
        logic [W-1:0] cur;
        while (idx < 2 && budget < 50) begin
            cur = (idx == 0) ? w0 : w1;
            cycle(1'b1, cur, 1'b0);
            if ((inst == 0 && acc0) || (inst == 1 && acc1)) idx++;
            budget++;
        end
        if (idx < 2) begin
            errors++;
            $display("FAIL send_pair_timeout inst %0d: accepted %0d want 2", inst, idx);
        end
    endtask

    initial begin
        // Reset held two cycles with din_valid asserted.
        cycle(1'b1, 4'hF, 1'b1);
        cycle(1'b1, 4'hF, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);

        // Reset after the second bit of 4'hF, then a clean word.
        cycle(1'b1, 4'hF, 1'b0);
        cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);

        // Single word 4'b1011 on both bit orders.
        cycle(1'b1, 4'b1011, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'h0, 1'b0);

        // Back-to-back A then 5 (no-gap instance), then two words on the gap instance.
        send_pair(0, 4'hA, 4'h5);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 1'b0);
        send_pair(1, 4'h3, 4'hC);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 1'b0);

        // Random valid pattern, then saturated traffic long enough to wrap word_count.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, W'($urandom), 1'b0);
        end
        for (int i = 0; i < 1100; i++) begin
            cycle(1'b1, W'($urandom), 1'b0);
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 4'h0, 1'b0);

        chk8("u0_queue_drained", 8'(q0.size()), 8'd0);
        chk8("u1_queue_drained", 8'(q1.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
